// File: rtl/descrambler_pkg.sv
// Shared definitions for the 32-bit additive descrambler and its matching scrambler.
// Holds the LFSR width, feedback tap positions, the zero-seed substitute and
// the FSM state encoding.
package descrambler_pkg;

  localparam int unsigned LFSR_W    = 32;
  localparam int unsigned CNT_W     = 16;

  // Feedback taps: fb = lfsr[0] ^ lfsr[10] ^ lfsr[30] ^ lfsr[31]
  localparam int unsigned TAP_0     = 0;
  localparam int unsigned TAP_1     = 10;
  localparam int unsigned TAP_2     = 30;
  localparam int unsigned TAP_3     = 31;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this value
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/descrambler_32_if.sv
// Stream + seed interface of descrambler_32.
// master: upstream/downstream side (drives seed, in_*, out_ready).
// slave : the descrambler (drives in_ready, out_*, word_count, seeded).
interface descrambler_32_if;
  import descrambler_pkg::*;

  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [LFSR_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  word_count;
  logic              seeded;

  modport master (
    output seed_load, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, word_count, seeded
  );

  modport slave (
    input  seed_load, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, word_count, seeded
  );

endinterface

// File: rtl/lfsr_step_32.sv
// Combinational single-step next-state function of the 32-bit keystream LFSR.
// Shared with the matching scrambler so both ends advance identically.
// Ports: i_lfsr (current state), o_lfsr_next_c (state after one shift).
module lfsr_step_32
  import descrambler_pkg::*;
(
  input  logic [LFSR_W-1:0] i_lfsr,
  output logic [LFSR_W-1:0] o_lfsr_next_c
);

  logic w_fb;

  assign w_fb          = i_lfsr[TAP_0] ^ i_lfsr[TAP_1] ^ i_lfsr[TAP_2] ^ i_lfsr[TAP_3];
  assign o_lfsr_next_c = {w_fb, i_lfsr[LFSR_W-1:1]};

endmodule

// File: rtl/descrambler_32.sv
// 32-bit additive descrambler: out_data = in_data ^ keystream, one-cycle latency,
// one-deep output register with valid/ready flow control.
// Ports: clk, rst (async active-high), bus (descrambler_32_if.slave):
//   seed_load/seed load the keystream, in_* upstream stream, out_* downstream
//   stream, word_count = words accepted since last seed load, seeded = in RUN.
module descrambler_32
  import descrambler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  descrambler_32_if.slave        bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] w_seed_value;
  logic [LFSR_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_word_count;
  logic              w_in_ready;
  logic              w_seeded;
  logic              w_accept;

  lfsr_step_32 u_lfsr_step (
    .i_lfsr        (r_lfsr),
    .o_lfsr_next_c (w_lfsr_next)
  );

  assign w_seed_value = (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;
  assign w_accept     = bus.in_valid && w_in_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state: any seed load lands in RUN, nothing else leaves a state
  always_comb begin
    w_next_state = r_state;
    if (bus.seed_load) w_next_state = ST_RUN;
  end

  // FSM outputs; a seed-load cycle never accepts so the old key is not misused
  always_comb begin
    w_in_ready = 1'b0;
    w_seeded   = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_seeded   = 1'b1;
        w_in_ready = !bus.seed_load && (!r_out_valid || bus.out_ready);
      end
      default: begin
        w_seeded   = 1'b0;
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Keystream and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= ZERO_SEED_SUB;
      r_word_count <= '0;
    end else if (bus.seed_load) begin
      r_lfsr       <= w_seed_value;
      r_word_count <= '0;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_next;
      if (r_word_count != {CNT_W{1'b1}}) r_word_count <= r_word_count + CNT_W'(1);
    end
  end

  // Output register; a pending word survives reseeding and stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data ^ r_lfsr;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.seeded     = w_seeded;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.word_count = r_word_count;

endmodule

// File: doc/descrambler_32.md
DESCRAMBLER_32 -- requirements
Module: descrambler_32

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have seed_load, input, 1, request to load a new keystream seed.
REQ-004 SHALL have seed, input, 32, seed value, sampled when seed_load=1.
REQ-005 SHALL have in_valid, input, 1, scrambled word present.
REQ-006 SHALL have in_data, input, 32, scrambled word.
REQ-007 SHALL have in_ready, output, 1, block accepts in_data this cycle.
REQ-008 SHALL have out_valid, output, 1, descrambled word present.
REQ-009 SHALL have out_data, output, 32, descrambled word.
REQ-010 SHALL have out_ready, input, 1, downstream accepts out_data this cycle.
REQ-011 SHALL have word_count, output, 16, words accepted since last seed load.
REQ-012 SHALL have seeded, output, 1, high in state RUN.

Function
REQ-013 SHALL implement a two-state FSM, IDLE (no seed) and RUN.
REQ-014 SHALL move IDLE->RUN on seed_load=1; RUN->RUN on seed_load=1 (reseed); no other transitions except reset.
REQ-015 SHALL load lfsr <= seed on seed_load, or 32'h0000_0001 if seed==0 (all-zero lock-up forbidden).
REQ-016 SHALL clear word_count to 0 on every seed load.
REQ-017 SHALL drive in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
REQ-018 SHALL define accept as in_valid && in_ready; in IDLE in_data is ignored and in_ready=0.
REQ-019 SHALL on accept register out_data <= in_data XOR lfsr and set out_valid=1, giving 1-cycle latency.
REQ-020 SHALL on accept advance lfsr exactly one step: lfsr <= {fb, lfsr[31:1]}, fb = lfsr[0]^lfsr[10]^lfsr[30]^lfsr[31].
REQ-021 SHALL clear out_valid when out_valid && out_ready and there is no accept in the same cycle.
REQ-022 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL support full throughput: with out_ready=1 constantly, one word per cycle.
REQ-024 SHALL, on simultaneous out-handshake and accept, replace out_data with the new word and keep out_valid=1.
REQ-025 SHALL, on seed_load in RUN, keep any pending output word valid and unchanged; the new seed applies only to words accepted afterwards.
REQ-026 SHALL increment word_count by 1 per accept, saturating at 16'hFFFF.
REQ-027 SHALL keep lfsr unchanged on cycles with no accept and no seed_load.

Reset
REQ-028 SHALL on rst=1 immediately force state=IDLE, lfsr=32'h0000_0001, out_valid=0, out_data=0, word_count=0, seeded=0, in_ready=0.
REQ-029 SHALL discard any pending output word when reset is asserted mid-stream; a seed load is required after reset release.

Structure
REQ-030 SHALL place LFSR width (32), tap positions (0,10,30,31), zero-seed substitute (32'h0000_0001) and FSM state encoding in shared package descrambler_pkg.
REQ-031 SHALL instantiate one sub-module lfsr_step_32 (combinational single-step next-state function), reusable by a matching scrambler.
REQ-032 SHALL realize the data combine as a 32-bit bitwise XOR of in_data and lfsr.

Verification
REQ-033 SHALL verify: seed_load with seed=0x0000_0001, then words 0xFFFF_FFFF, 0x0000_0000, 0x0000_0000 with out_ready=1 -> outputs 0xFFFF_FFFE, 0x8000_0000, 0xC000_0000, each one cycle after accept.
REQ-034 SHALL verify: seed=0x0000_0000 -> behaves identically to seed=0x0000_0001 (same output sequence as REQ-033).
REQ-035 SHALL verify: out_ready=0 for 3 cycles with a word pending -> out_data stable, in_ready=0, lfsr and word_count unchanged; release -> stream resumes with no loss or duplication.
REQ-036 SHALL verify: in_valid=1 while in IDLE -> in_ready=0, out_valid stays 0, word_count stays 0.
REQ-037 SHALL verify: reseed mid-stream with a word pending -> pending word delivered unchanged, word_count=0, next word XORed with new seed.
REQ-038 SHALL verify: scrambler model (same LFSR, same seed) feeding 1000 random words with random out_ready -> recovered data equals original plaintext; rst mid-stream -> all outputs at reset values within the reset cycle.
